// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and configuration limits for mem_port_arbiter.
//   arb_state_e      : FSM state encoding (IDLE/ISSUE/WAIT/DONE)
//   OWN_IF / OWN_DM  : owner encoding
//   *_MIN / *_MAX    : legal parameter ranges for MEM_LAT and STARVE_LIMIT
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int MEM_LAT_MIN      = 1;
  localparam int MEM_LAT_MAX      = 7;
  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 15;

  localparam int LAT_CNT_W    = 3;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// arb_lat_counter: 3-bit loadable down-counter that times the WAIT state.
//   clk, reset   : clock, async active-low reset
//   i_load       : load i_load_val (has priority over i_en)
//   i_load_val   : value to load
//   i_en         : decrement by one; holds at zero
//   o_zero       : count is zero
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [LAT_CNT_W-1:0] i_load_val,
  input  logic                 i_en,
  output logic                 o_zero
);

  logic [LAT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the
// instruction-fetch (IF) and data-memory (DM) requesters.
//   clk, reset              : clock, async active-low reset
//   if_req/if_addr          : fetch request, held until if_rvalid
//   if_rdata/if_rvalid      : registered fetch data, one-cycle completion pulse
//   if_stall                : if_req & ~if_rvalid
//   dm_req/we/addr/wdata    : data request, held until dm_rvalid
//   dm_rdata/dm_rvalid      : registered read data, one-cycle completion pulse
//   dm_stall                : dm_req & ~dm_rvalid
//   mem_en/we/addr/wdata    : memory access, mem_en is a one-cycle strobe
//   mem_rdata               : memory read data, valid MEM_LAT cycles after mem_en
//   busy                    : FSM not in IDLE
//   owner                   : 0 = IF, 1 = DM (current or last grant)
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the IF
// starvation guard; otherwise DM has strict priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_rvalid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam bit CFG_OK = (MEM_LAT >= MEM_LAT_MIN) && (MEM_LAT <= MEM_LAT_MAX) &&
                          (STARVE_LIMIT >= STARVE_LIMIT_MIN) &&
                          (STARVE_LIMIT <= STARVE_LIMIT_MAX);
  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("mem_port_arbiter: MEM_LAT or STARVE_LIMIT out of range");
    end
  endgenerate

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_is_wr;     // access in flight is a DM write
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;

  logic w_any_req;
  logic w_grant_dm;
  logic w_starve_fire;
  logic w_lat_zero;

  assign w_any_req = if_req | dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  // Count DM wins that left IF waiting; at the limit IF takes the next grant,
  // so the count can never pass STARVE_LIMIT.
  assign w_starve_fire = if_req && (r_starve_cnt == STARVE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_starve_cnt <= '0;
    else if (r_state == IDLE && w_any_req) begin
      if (!w_grant_dm)  r_starve_cnt <= '0;
      else if (if_req)  r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_starve_fire = 1'b0;
`endif

  assign w_grant_dm = dm_req & ~w_starve_fire;

  arb_lat_counter u_lat (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == ISSUE),
    .i_load_val (LAT_LOAD),
    .i_en       (r_state == WAIT),
    .o_zero     (w_lat_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_is_wr     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
    end else begin
      // strobes are single-cycle by default
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        IDLE: if (w_any_req) begin
          r_owner    <= w_grant_dm ? OWN_DM : OWN_IF;
          r_mem_addr <= w_grant_dm ? dm_addr : if_addr;
          r_is_wr    <= w_grant_dm & dm_we;
          r_mem_we   <= w_grant_dm & dm_we;
          if (w_grant_dm) r_mem_wdata <= dm_wdata;
          r_mem_en   <= 1'b1;
          r_state    <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: if (w_lat_zero) begin
          if (r_owner == OWN_IF) begin
            r_if_rdata  <= mem_rdata;
            r_if_rvalid <= 1'b1;
          end else begin
            if (!r_is_wr) r_dm_rdata <= mem_rdata;
            r_dm_rvalid <= 1'b1;
          end
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_stall  = if_req & ~r_if_rvalid;
  assign dm_stall  = dm_req & ~r_dm_rvalid;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != IDLE);
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_LIMIT=4).
// Memory model: read data is a fixed function of the registered address.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_rvalid, if_stall, dm_rvalid, dm_stall;
  logic        mem_en, mem_we, busy, owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_rvalid(if_rvalid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h4) return 32'h8C08_0000;
    return {~a[15:0], a[15:0] ^ 16'h5A5A};
  endfunction

  assign mem_rdata = data_of(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ifr;  logic [31:0] ifa;
    logic        dmr;  logic dmw; logic [31:0] dma; logic [31:0] dmd;
    logic [7:0]  ctl;  // {mem_en, mem_we, if_rv, dm_rv, if_stall, dm_stall, busy, owner}
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ifr, input logic [31:0] ifa, input logic dmr, input logic dmw,
                     input logic [31:0] dma, input logic [31:0] dmd,
                     input logic en, input logic we, input logic ifv, input logic dmv,
                     input logic ifs, input logic dms, input logic bsy, input logic own,
                     input logic [31:0] ea, input logic [31:0] ew, input logic [31:0] er);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw; v.dma = dma; v.dmd = dmd;
    v.ctl = {en, we, ifv, dmv, ifs, dms, bsy, own};
    v.e_addr = ea; v.e_wdata = ew; v.e_rdata = er;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int grants, if_grant_at, idx, n_en, bad;
    int en_cyc[3];
    logic adv;

    // Fetch 0x4; simultaneous IF 0x0 / DM 0x10; DM write 0x20.
    //   ifr ifa   dmr dmw dma    dmd            en we iv dv is ds bs ow  addr   wdata          rdata
    add(1, 32'h4, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h4, 0, 0, 32'h0,  32'h0,          1, 0, 0, 0, 1, 0, 1, 0, 32'h4, 32'h0, 32'h0);
    add(1, 32'h4, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h4, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h4, 0, 0, 32'h0,  32'h0,          0, 0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h8C08_0000);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 1, 0, 32'h10, 32'h0,          0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 1, 0, 32'h10, 32'h0,          1, 0, 0, 0, 1, 1, 1, 1, 32'h10, 32'h0, 32'h0);
    add(1, 32'h0, 1, 0, 32'h10, 32'h0,          0, 0, 0, 0, 1, 1, 1, 1, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 1, 0, 32'h10, 32'h0,          0, 0, 0, 0, 1, 1, 1, 1, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 1, 0, 32'h10, 32'h0,          0, 0, 0, 1, 1, 0, 1, 1, 32'h0, 32'h0, 32'hFFEF_5A4A);
    add(1, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 0, 0, 32'h0,  32'h0,          1, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    add(1, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'hFFFF_5A5A);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    add(0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF,   0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    add(0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF,   1, 1, 0, 0, 0, 1, 1, 1, 32'h20, 32'hDEADBEEF, 32'h0);
    add(0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF,   0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0);
    add(0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF,   0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0);
    add(0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF,   0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 32'h0, 32'hFFEF_5A4A);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);

    // Reset state; stall follows its equation even in reset.
    if_req = 1'b1;
    #12;
    chk("reset ctl", {24'h0, mem_en, mem_we, if_rvalid, dm_rvalid, if_stall, dm_stall, busy, owner},
        32'h0000_0008);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset dm_rdata", dm_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    if_req = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Vector table: drive after each rising edge, sample on the falling edge.
    foreach (vecs[k]) begin
      @(posedge clk); #1;
      if_req = vecs[k].ifr; if_addr = vecs[k].ifa;
      dm_req = vecs[k].dmr; dm_we = vecs[k].dmw; dm_addr = vecs[k].dma; dm_wdata = vecs[k].dmd;
      @(negedge clk);
      chk($sformatf("row %0d ctl", k),
          {24'h0, mem_en, mem_we, if_rvalid, dm_rvalid, if_stall, dm_stall, busy, owner},
          {24'h0, vecs[k].ctl});
      if (vecs[k].ctl[7]) chk($sformatf("row %0d mem_addr", k), mem_addr, vecs[k].e_addr);
      if (vecs[k].ctl[6]) chk($sformatf("row %0d mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      if (vecs[k].ctl[5]) chk($sformatf("row %0d if_rdata", k), if_rdata, vecs[k].e_rdata);
      if (vecs[k].ctl[4]) chk($sformatf("row %0d dm_rdata", k), dm_rdata, vecs[k].e_rdata);
    end

    // Starvation: both requesters held; track which arbitration goes to IF.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    grants = 0; if_grant_at = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int cyc = 0; cyc < 200 && grants < 5; cyc++) begin
`else
    for (int cyc = 0; cyc < 200 && grants < 20; cyc++) begin
`endif
      @(negedge clk);
      if (mem_en) begin
        grants++;
        if (mem_addr == 32'h40 && if_grant_at == 0) if_grant_at = grants;
      end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve grants seen", grants, 5);
    chk("starve IF grant index", if_grant_at, 5);
`else
    chk("starve grants seen", grants, 20);
    chk("starve IF grant index", if_grant_at, 0);
`endif
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
    @(negedge clk);
    chk("starve drained busy", busy, 0);

    // Reset during WAIT: outputs drop before the next edge, no stale rvalid.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0; #1;
    chk("rst mid ctl", {28'h0, busy, mem_en, if_rvalid, dm_rvalid}, 32'h0);
    chk("rst mid dm_stall", dm_stall, 1);
    chk("rst mid dm_rdata", dm_rdata, 32'h0);
    dm_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    bad = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (busy || if_rvalid || dm_rvalid || mem_en) bad++;
    end
    chk("rst after release quiet cycles", bad, 0);

    // Back-to-back fetches with a new address after each if_rvalid.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    idx = 0; n_en = 0; adv = 1'b0;
    for (int cyc = 0; cyc < 100 && idx < 3; cyc++) begin
      @(negedge clk);
      if (mem_en) begin
        chk($sformatf("b2b %0d mem_addr", idx), mem_addr, 32'h100 + 32'(4 * idx));
        if (n_en < 3) en_cyc[n_en] = cyc;
        n_en++;
      end
      if (if_rvalid) begin
        chk($sformatf("b2b %0d if_rdata", idx), if_rdata, data_of(32'h100 + 32'(4 * idx)));
        adv = 1'b1;
      end
      @(posedge clk); #1;
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 3) if_addr = 32'h100 + 32'(4 * idx);
        else         if_req = 1'b0;
      end
    end
    chk("b2b completions", idx, 3);
    chk("b2b mem_en count", n_en, 3);
    if (n_en >= 3) begin
      chk("b2b gap 1", en_cyc[1] - en_cyc[0], 5);
      chk("b2b gap 2", en_cyc[2] - en_cyc[1], 5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Arbitrates a single-ported, fixed-latency memory between two requesters: the pipeline's instruction-fetch port (IF) and its data-memory port (DM).
- Sequences each access through a small state machine.
- Produces per-port stall signals so the pipeline can freeze the IF/ID and ID/EX registers while its port waits.
- Sits between the pipeline stages and the shared instruction/data memory.

## Interface
Parameters:
- ADDR_W, 32: address width
- DATA_W, 32: data width
- MEM_LAT, 2: cycles from mem_en sampled to mem_rdata valid; legal range 1..7
- STARVE_LIMIT, 4: consecutive DM grants with IF waiting before IF is forced; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_rvalid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_rvalid  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_rvalid (combinational)
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_rvalid
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data, registered
- dm_rvalid  out  1  one-cycle completion pulse for DM, both reads and writes
- dm_stall  out  1  dm_req & ~dm_rvalid (combinational)
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered access address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = IF, 1 = DM; current or last grant

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise pick a winner. DM wins by default; IF wins if only IF requests, or if the starvation guard fires.
  - Register mem_addr, mem_we (IF always 0), mem_wdata and owner, then go to ISSUE.
- **ISSUE**
  - mem_en = 1 for this cycle only.
  - Load the latency counter with MEM_LAT-1, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register (DM writes capture nothing) and go to DONE.
- **DONE**
  - Owner's rvalid = 1; then go to IDLE.
  - No arbitration happens in DONE. The served requester updates its req on the edge that ends DONE.
- Both requesters active in IDLE: exactly one is granted. The loser's request stays pending and is arbitrated on the next IDLE visit.
- Outputs:
  - if_rdata and dm_rdata hold their value until the next capture for that port.
  - dm_rdata is unchanged by writes.
  - mem_en, mem_we, if_rvalid and dm_rvalid are 0 outside the states above.
- Reset (async, active low) forces IDLE immediately.
  - Registered outputs all reset to 0: if_rdata, dm_rdata, rvalids, mem_*, owner.
  - busy reset value is 0.
  - The starvation counter resets to 0.
  - An access in flight is abandoned with no rvalid.
  - The stall outputs follow their equations.

## Timing
- Request sampled in IDLE at cycle n:
  - cycle n+1: ISSUE, mem_en high
  - cycle n+1+MEM_LAT: mem_rdata valid
  - cycle n+2+MEM_LAT: DONE, rvalid high
  - cycle n+3+MEM_LAT: IDLE
- Occupancy is MEM_LAT+3 cycles per access, so peak throughput is one access per MEM_LAT+3 cycles.
- A request held continuously from an idle arbiter completes after MEM_LAT+2 cycles.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - 4-bit counter increments on each DM grant while if_req is high.
  - Clears on an IF grant.
  - When the count equals STARVE_LIMIT and if_req is high, IF wins the next arbitration.
- Undefined: strict DM priority, and no counter logic exists. IF can starve while dm_req stays high.

## Structure
- Shared package mem_arb_pkg holds:
  - state encodings (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3)
  - owner encodings (OWN_IF = 1'b0, OWN_DM = 1'b1)
  - the MEM_LAT and STARVE_LIMIT legal-range constants
- One sub-module, arb_lat_counter: 3-bit loadable down-counter with load, enable and zero outputs, used for WAIT.

## Test plan
All scenarios use MEM_LAT=2.
1. **Single fetch:** if_req with if_addr=0x00000004 at cycle 0, memory returns 0x8C080000 → mem_en in cycle 1 only with mem_addr=0x4 and mem_we=0; if_rvalid in cycle 4 with if_rdata=0x8C080000; if_stall high in cycles 0–3.
2. **Simultaneous requests:** IF reads 0x0 and DM reads 0x10 at cycle 0 → DM served first (mem_en cycle 1, dm_rvalid cycle 4); IF mem_en in cycle 6, if_rvalid in cycle 9.
3. **DM write:** dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF → mem_en=mem_we=1 for one cycle with matching addr/data; dm_rvalid pulse in cycle 4; dm_rdata unchanged.
4. **Starvation:** STARVE_LIMIT=4, dm_req and if_req held high → with the guard, IF granted on the 5th arbitration; without the guard, no IF grant across 20 DM transactions.
5. **Reset mid-access:** reset driven low during WAIT → busy, mem_en and both rvalids 0 before the next clock edge; after release, IDLE and no stale rvalid.
6. **Back-to-back fetches:** if_req held with a new address each time after if_rvalid → mem_en pulses exactly 5 cycles apart, and data matches per address.
